slave_rx_port: RTL and testbench

SLAVE_RX_PORT -- requirements
Module: slave_rx_port

---
 rtl/slave_rx_port.sv | 243 ++++++++++++++++++++++++
 tb/tb_slave_rx_port.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_rx_port.sv
// slave_rx_port
//   Serial receive port for a slave device. A master presents a frame LSB
//   first on two serial lines: rx_address carries ADDR_WIDTH address bits and
//   rx_data carries DATA_WIDTH data bits (writes only). A frame starts on a
//   master_valid & slave_ready handshake in IDLE. Bursts continue from
//   WAIT_BEAT with the address auto-incremented; write continuation beats
//   shift in a fresh data word, read continuation beats complete in one cycle.
//
//   Optional feature: define SLAVE_RX_PARITY_EN to append one even-parity
//   cycle (sampled on rx_data) after every beat that captured serial bits.
//   A failing parity check raises parity_err with rx_done and suppresses the
//   read/write strobes. Without the macro parity_err is tied to 0.
//
// Ports
//   clk            clock, all logic on the rising edge
//   reset          asynchronous, active-high
//   rx_address     serial address bit, LSB first
//   rx_data        serial data bit, LSB first
//   master_valid   master requests a frame / continuation beat
//   read_en        frame is a read (sampled at the IDLE handshake)
//   write_en       frame is a write (wins over read_en)
//   burst          beats per transaction, 0 behaves as 1
//   mem_busy       memory-side backpressure, blocks new handshakes only
//   slave_ready    port can accept a handshake this cycle
//   rx_done        one-cycle pulse, address/data of a beat are valid
//   address        received (or incremented) address
//   data           received data word
//   read_en_in     read strobe, coincident with rx_done
//   write_en_in    write strobe, coincident with rx_done
//   burst_counter  beats completed in the current burst
//   parity_err     parity failure on the beat flagged by rx_done
module slave_rx_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_address,
  input  logic                   rx_data,
  input  logic                   master_valid,
  input  logic                   read_en,
  input  logic                   write_en,
  input  logic [BURST_WIDTH-1:0] burst,
  input  logic                   mem_busy,
  output logic                   slave_ready,
  output logic                   rx_done,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic [DATA_WIDTH-1:0]  data,
  output logic                   read_en_in,
  output logic                   write_en_in,
  output logic [BURST_WIDTH-1:0] burst_counter,
  output logic                   parity_err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT_BEAT,
    DATA,
`ifdef SLAVE_RX_PARITY_EN
    PARITY,
`endif
    DONE
  } state_t;

  // State entered once the last serial bit of a beat has been sampled.
`ifdef SLAVE_RX_PARITY_EN
  localparam state_t BEAT_END = PARITY;
`else
  localparam state_t BEAT_END = DONE;
`endif

  localparam logic [ADDR_WIDTH-1:0]  FIRST_ADDR_BIT = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]  FIRST_DATA_BIT = DATA_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE      = BURST_WIDTH'(1);

  state_t                   state_reg, state_next;
  // One-hot pointer to the bit position sampled in the current cycle.
  logic [ADDR_WIDTH-1:0]    mask_reg, mask_next;
  logic [ADDR_WIDTH-1:0]    address_reg, address_next;
  logic [DATA_WIDTH-1:0]    data_reg, data_next;
  logic                     read_reg, read_next;
  logic                     write_reg, write_next;
  logic [BURST_WIDTH-1:0]   burst_reg, burst_next;
  logic [BURST_WIDTH-1:0]   burst_counter_reg, burst_counter_next;
  logic                     handshake;
  logic                     beat_ok;
`ifdef SLAVE_RX_PARITY_EN
  // Running XOR of every bit captured in the current beat.
  logic                     parity_acc_reg, parity_acc_next;
  logic                     parity_err_reg, parity_err_next;
`endif

  assign slave_ready = ((state_reg == IDLE) || (state_reg == WAIT_BEAT)) && !mem_busy;
  assign handshake   = master_valid & slave_ready;
  assign rx_done     = (state_reg == DONE);

`ifdef SLAVE_RX_PARITY_EN
  assign beat_ok    = ~parity_err_reg;
  assign parity_err = rx_done & parity_err_reg;
`else
  assign beat_ok    = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign read_en_in    = rx_done & read_reg & beat_ok;
  assign write_en_in   = rx_done & write_reg & beat_ok;
  assign address       = address_reg;
  assign data          = data_reg;
  assign burst_counter = burst_counter_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      mask_reg          <= '0;
      address_reg       <= '0;
      data_reg          <= '0;
      read_reg          <= 1'b0;
      write_reg         <= 1'b0;
      burst_reg         <= '0;
      burst_counter_reg <= '0;
`ifdef SLAVE_RX_PARITY_EN
      parity_acc_reg    <= 1'b0;
      parity_err_reg    <= 1'b0;
`endif
    end else begin
      state_reg         <= state_next;
      mask_reg          <= mask_next;
      address_reg       <= address_next;
      data_reg          <= data_next;
      read_reg          <= read_next;
      write_reg         <= write_next;
      burst_reg         <= burst_next;
      burst_counter_reg <= burst_counter_next;
`ifdef SLAVE_RX_PARITY_EN
      parity_acc_reg    <= parity_acc_next;
      parity_err_reg    <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next         = state_reg;
    mask_next          = mask_reg;
    address_next       = address_reg;
    data_next          = data_reg;
    read_next          = read_reg;
    write_next         = write_reg;
    burst_next         = burst_reg;
    burst_counter_next = burst_counter_reg;
`ifdef SLAVE_RX_PARITY_EN
    parity_acc_next    = parity_acc_reg;
    parity_err_next    = parity_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (handshake) begin
          address_next = (address_reg & ~FIRST_ADDR_BIT) | (FIRST_ADDR_BIT & {ADDR_WIDTH{rx_address}});
          if (write_en)
            data_next = (data_reg & ~FIRST_DATA_BIT) | (FIRST_DATA_BIT & {DATA_WIDTH{rx_data}});
          // Both strobes requested: the frame is a write.
          read_next          = read_en & ~write_en;
          write_next         = write_en;
          burst_next         = (burst == '0) ? BURST_ONE : burst;
          burst_counter_next = '0;
          mask_next          = FIRST_ADDR_BIT << 1;
`ifdef SLAVE_RX_PARITY_EN
          parity_acc_next    = rx_address ^ (write_en & rx_data);
          parity_err_next    = 1'b0;
`endif
          state_next = (ADDR_WIDTH == 1) ? BEAT_END : ADDR;
        end
      end

      ADDR: begin
        address_next = (address_reg & ~mask_reg) | (mask_reg & {ADDR_WIDTH{rx_address}});
        // Data bits ride alongside the first DATA_WIDTH address bits.
        if (write_reg)
          data_next = (data_reg & ~mask_reg[DATA_WIDTH-1:0]) |
                      (mask_reg[DATA_WIDTH-1:0] & {DATA_WIDTH{rx_data}});
`ifdef SLAVE_RX_PARITY_EN
        parity_acc_next = parity_acc_reg ^ rx_address ^
                          (write_reg & (|mask_reg[DATA_WIDTH-1:0]) & rx_data);
`endif
        mask_next = mask_reg << 1;
        if (mask_reg[ADDR_WIDTH-1])
          state_next = BEAT_END;
      end

      WAIT_BEAT: begin
        if (handshake) begin
          address_next = address_reg + FIRST_ADDR_BIT;
`ifdef SLAVE_RX_PARITY_EN
          parity_err_next = 1'b0;
`endif
          if (write_reg) begin
            data_next = (data_reg & ~FIRST_DATA_BIT) | (FIRST_DATA_BIT & {DATA_WIDTH{rx_data}});
            mask_next = FIRST_ADDR_BIT << 1;
`ifdef SLAVE_RX_PARITY_EN
            parity_acc_next = rx_data;
`endif
            state_next = (DATA_WIDTH == 1) ? BEAT_END : DATA;
          end else begin
            // Read continuation carries no serial payload.
            state_next = DONE;
          end
        end
      end

      DATA: begin
        data_next = (data_reg & ~mask_reg[DATA_WIDTH-1:0]) |
                    (mask_reg[DATA_WIDTH-1:0] & {DATA_WIDTH{rx_data}});
`ifdef SLAVE_RX_PARITY_EN
        parity_acc_next = parity_acc_reg ^ rx_data;
`endif
        mask_next = mask_reg << 1;
        if (mask_reg[DATA_WIDTH-1])
          state_next = BEAT_END;
      end

`ifdef SLAVE_RX_PARITY_EN
      PARITY: begin
        // Even parity: captured bits XOR parity bit must be zero.
        parity_err_next = parity_acc_reg ^ rx_data;
        state_next      = DONE;
      end
`endif

      DONE: begin
        state_next = (burst_counter_reg < burst_reg) ? WAIT_BEAT : IDLE;
      end

      default: state_next = IDLE;
    endcase

    // The beat count becomes visible in the same cycle as rx_done.
    if ((state_next == DONE) && (state_reg != DONE))
      burst_counter_next = burst_counter_next + BURST_ONE;
  end

endmodule

// File: tb/tb_slave_rx_port.sv
`timescale 1ns/1ps
module tb_slave_rx_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 12;
`ifdef SLAVE_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_address = 1'b0, rx_data = 1'b0, master_valid = 1'b0;
  logic          read_en = 1'b0, write_en = 1'b0, mem_busy = 1'b0;
  logic [BW-1:0] burst = '0;
  logic          slave_ready, rx_done, read_en_in, write_en_in, parity_err;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic [BW-1:0] burst_counter;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            chk_data;
    logic          rd;
    logic          wr;
    logic [BW-1:0] bc;
    logic          perr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  slave_rx_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .rx_address(rx_address), .rx_data(rx_data),
    .master_valid(master_valid), .read_en(read_en), .write_en(write_en),
    .burst(burst), .mem_busy(mem_busy), .slave_ready(slave_ready),
    .rx_done(rx_done), .address(address), .data(data),
    .read_en_in(read_en_in), .write_en_in(write_en_in),
    .burst_counter(burst_counter), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every rx_done pulse consumes one expected beat.
  always @(negedge clk) begin
    if (reset === 1'b0 && rx_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rx_done cyc=%0d addr=%h want=no pulse", cyc, address);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (cyc !== mon_e.cyc) begin failures++; $display("FAIL done_cycle got=%0d want=%0d", cyc, mon_e.cyc); end
        checks++;
        if (address !== mon_e.addr) begin failures++; $display("FAIL address got=%h want=%h", address, mon_e.addr); end
        if (mon_e.chk_data) begin
          checks++;
          if (data !== mon_e.data) begin failures++; $display("FAIL data got=%h want=%h", data, mon_e.data); end
        end
        checks++;
        if (read_en_in !== mon_e.rd) begin failures++; $display("FAIL read_en_in got=%b want=%b", read_en_in, mon_e.rd); end
        checks++;
        if (write_en_in !== mon_e.wr) begin failures++; $display("FAIL write_en_in got=%b want=%b", write_en_in, mon_e.wr); end
        checks++;
        if (burst_counter !== mon_e.bc) begin failures++; $display("FAIL burst_counter got=%0d want=%0d", burst_counter, mon_e.bc); end
        checks++;
        if (parity_err !== mon_e.perr) begin failures++; $display("FAIL parity_err got=%b want=%b", parity_err, mon_e.perr); end
        $display("beat cyc=%0d addr=%h data=%h rd=%b wr=%b bc=%0d perr=%b",
                 cyc, address, data, read_en_in, write_en_in, burst_counter, parity_err);
      end
    end
  end

  task automatic wait_ready(input int limit);
    for (int n = 0; n < limit && slave_ready !== 1'b1; n++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (slave_ready !== 1'b1) begin
      failures++; $display("FAIL ready_timeout got=%b want=1", slave_ready);
    end
  endtask

  // Starts a frame from IDLE and returns in the cycle rx_done is expected.
  task automatic drive_frame(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic rd, input logic wr, input logic [BW-1:0] b,
                             input logic bad, input logic busy_mid);
    exp_t e;
    logic par;
    master_valid = 1'b1; read_en = rd; write_en = wr; burst = b;
    wait_ready(50);
    e.cyc = cyc + AW + PB; e.addr = a; e.data = d; e.chk_data = wr;
    e.rd = rd & ~wr & ~bad; e.wr = wr & ~bad; e.bc = 1; e.perr = bad;
    sb.push_back(e);
    par = (^a) ^ (wr ? (^d) : 1'b0) ^ bad;
    for (int i = 0; i < AW; i++) begin
      rx_address = a[i];
      if (wr && i < DW) rx_data = d[i]; else rx_data = 1'b0;
      @(posedge clk); #1;
      if (i == 0) begin
        master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0; burst = '0;
        if (busy_mid) mem_busy = 1'b1;
      end
    end
    if (PB != 0) begin
      rx_data = par; @(posedge clk); #1;
    end
    rx_address = 1'b0; rx_data = 1'b0; mem_busy = 1'b0;
  endtask

  // Continuation beat from WAIT_BEAT; returns in the expected rx_done cycle.
  task automatic drive_beat(input logic [DW-1:0] d, input logic [AW-1:0] exp_a,
                            input logic [BW-1:0] exp_bc, input logic rd, input logic wr);
    exp_t e;
    master_valid = 1'b1;
    wait_ready(50);
    e.cyc = wr ? (cyc + DW + PB) : (cyc + 1); e.addr = exp_a; e.data = d; e.chk_data = wr;
    e.rd = rd & ~wr; e.wr = wr; e.bc = exp_bc; e.perr = 1'b0;
    sb.push_back(e);
    rx_data = wr ? d[0] : 1'b0;
    @(posedge clk); #1;
    master_valid = 1'b0;
    if (wr) begin
      for (int i = 1; i < DW; i++) begin
        rx_data = d[i]; @(posedge clk); #1;
      end
      if (PB != 0) begin
        rx_data = ^d; @(posedge clk); #1;
      end
    end
    rx_data = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (slave_ready !== 1'b1) begin failures++; $display("FAIL reset_slave_ready got=%b want=1", slave_ready); end
    checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done got=%b want=0", rx_done); end
    checks++; if (address !== '0) begin failures++; $display("FAIL reset_address got=%h want=000", address); end
    checks++; if (data !== '0) begin failures++; $display("FAIL reset_data got=%h want=00", data); end
    checks++; if (burst_counter !== '0) begin failures++; $display("FAIL reset_burst_counter got=%0d want=0", burst_counter); end
    checks++; if ({read_en_in, write_en_in, parity_err} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b want=000", {read_en_in, write_en_in, parity_err}); end
    mem_busy = 1'b1; #1;
    checks++; if (slave_ready !== 1'b0) begin failures++; $display("FAIL reset_busy_ready got=%b want=0", slave_ready); end
    mem_busy = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_single_write;
    drive_frame(12'hA5C, 8'h3E, 1'b0, 1'b1, 12'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if (rx_done !== 1'b0 || slave_ready !== 1'b1) begin failures++; $display("FAIL single_write_idle got=%b%b want=01", rx_done, slave_ready); end
    checks++; if (address !== 12'hA5C || data !== 8'h3E) begin failures++; $display("FAIL single_write_hold got=%h/%h want=a5c/3e", address, data); end
    $display("test_single_write done");
  endtask

  task automatic test_read_burst;
    drive_frame(12'hFFE, 8'h00, 1'b1, 1'b0, 12'd3, 1'b0, 1'b0);
    drive_beat(8'h00, 12'hFFF, 12'd2, 1'b1, 1'b0);
    drive_beat(8'h00, 12'h000, 12'd3, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (slave_ready !== 1'b1 || address !== 12'h000) begin failures++; $display("FAIL read_burst_end got=%b/%h want=1/000", slave_ready, address); end
    $display("test_read_burst done");
  endtask

  task automatic test_write_burst_delayed;
    drive_frame(12'h3FF, 8'h11, 1'b0, 1'b1, 12'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if (slave_ready !== 1'b1 || rx_done !== 1'b0) begin failures++; $display("FAIL wait_beat_hold got=%b%b want=10", slave_ready, rx_done); end
    end
    checks++; if (address !== 12'h3FF || data !== 8'h11) begin failures++; $display("FAIL wait_beat_regs got=%h/%h want=3ff/11", address, data); end
    drive_beat(8'h22, 12'h400, 12'd2, 1'b0, 1'b1);
    $display("test_write_burst_delayed done");
  endtask

  task automatic test_mem_busy;
    mem_busy = 1'b1; master_valid = 1'b1; read_en = 1'b1; write_en = 1'b1; rx_address = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (slave_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b want=0", slave_ready); end
    end
    checks++; if (address !== 12'h400) begin failures++; $display("FAIL busy_no_capture got=%h want=400", address); end
    mem_busy = 1'b0; #1;
    checks++; if (slave_ready !== 1'b1) begin failures++; $display("FAIL busy_release_ready got=%b want=1", slave_ready); end
    drive_frame(12'h5A5, 8'hC3, 1'b1, 1'b1, 12'd1, 1'b0, 1'b0);
    $display("test_mem_busy done");
  endtask

  task automatic test_no_strobe;
    drive_frame(12'h0F0, 8'h00, 1'b0, 1'b0, 12'd0, 1'b0, 1'b1);
    checks++; if (data !== 8'hC3) begin failures++; $display("FAIL no_strobe_data got=%h want=c3", data); end
    $display("test_no_strobe done");
  endtask

  task automatic test_reset_mid_frame;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = 12'h777; d = 8'h55;
    master_valid = 1'b1; write_en = 1'b1; burst = 12'd1;
    wait_ready(50);
    for (int i = 0; i < 5; i++) begin
      rx_address = a[i]; rx_data = d[i];
      @(posedge clk); #1;
      master_valid = 1'b0; write_en = 1'b0;
    end
    reset = 1'b1; #1;
    checks++; if (rx_done !== 1'b0 || read_en_in !== 1'b0 || write_en_in !== 1'b0 || parity_err !== 1'b0) begin failures++; $display("FAIL mid_reset_strobes got=%b%b%b%b want=0000", rx_done, read_en_in, write_en_in, parity_err); end
    checks++; if (address !== '0 || data !== '0 || burst_counter !== '0) begin failures++; $display("FAIL mid_reset_regs got=%h/%h/%0d want=000/00/0", address, data, burst_counter); end
    checks++; if (slave_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b want=1", slave_ready); end
    @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rx_address = a[i % AW]; @(posedge clk); #1;
    end
    rx_address = 1'b0; rx_data = 1'b0;
    drive_frame(12'h9C3, 8'hA7, 1'b0, 1'b1, 12'd1, 1'b0, 1'b0);
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_parity;
`ifdef SLAVE_RX_PARITY_EN
    @(posedge clk); #1;
    drive_frame(12'h246, 8'h81, 1'b0, 1'b1, 12'd1, 1'b1, 1'b0);
    drive_frame(12'h135, 8'h7E, 1'b0, 1'b1, 12'd1, 1'b0, 1'b0);
    $display("test_parity done");
`else
    $display("test_parity skipped");
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_write_burst_delayed();
    test_mem_busy();
    test_no_strobe();
    test_reset_mid_frame();
    test_parity();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL missing_beats got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
